// File: rtl/dlfloat_operand_tx_if.sv
// dlfloat_operand_tx_if: operand-pair input handshake plus the two-beat DLFloat16 transmit bus.
interface dlfloat_operand_tx_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        tx_ready;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_beat;
  modport master (output in_valid, in_a, in_b, tx_ready, input in_ready, tx_valid, tx_data, tx_beat);
  modport slave  (input in_valid, in_a, in_b, tx_ready, output in_ready, tx_valid, tx_data, tx_beat);
endinterface

// File: rtl/dlfloat_operand_tx.sv
// dlfloat_operand_tx: buffers (a,b) pairs in a FIFO and sends each as beat A then beat B.
// Optional DLF_CANON_ZERO_EN stores -0 operands as +0 at push.
module dlfloat_operand_tx #(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  dlfloat_operand_tx_if.slave bus,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;
  state_t         state;
  logic [31:0]    mem [DEPTH];
  logic [31:0]    head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [15:0]    frame_b, a_st, b_st;
  logic           push, pop, non_empty;
  assign non_empty   = fifo_count != '0;
  assign bus.in_ready = fifo_count != CNT_W'(DEPTH);
  assign push        = bus.in_valid & bus.in_ready;
  assign pop         = non_empty & (state == IDLE | (state == SEND_B & bus.tx_ready));
  assign busy        = non_empty | (state != IDLE);
  assign head        = mem[rd_ptr];
`ifdef DLF_CANON_ZERO_EN
  assign a_st = bus.in_a == 16'h8000 ? 16'h0000 : bus.in_a;
  assign b_st = bus.in_b == 16'h8000 ? 16'h0000 : bus.in_b;
`else
  assign a_st = bus.in_a;
  assign b_st = bus.in_b;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {a_st, b_st};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      state        <= IDLE;
      frame_b      <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
      bus.tx_beat  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      // a pop always loads a fresh frame and presents its A beat
      if (pop) begin
        bus.tx_data  <= head[31:16];
        frame_b      <= head[15:0];
        bus.tx_beat  <= 1'b0;
        bus.tx_valid <= 1'b1;
        state        <= SEND_A;
      end else begin
        case (state)
          SEND_A:
            if (bus.tx_ready) begin
              bus.tx_data <= frame_b;
              bus.tx_beat <= 1'b1;
              state       <= SEND_B;
            end
          SEND_B:
            if (bus.tx_ready) begin
              bus.tx_valid <= 1'b0;
              bus.tx_data  <= '0;
              bus.tx_beat  <= 1'b0;
              state        <= IDLE;
            end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dlfloat_operand_tx.sv
// tb_dlfloat_operand_tx: directed and random checks against a beat-order scoreboard.
module tb_dlfloat_operand_tx;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] fifo_count;
  logic busy;
  int nchk = 0;
  int nerr = 0;
  logic [16:0] exp_q[$];
  always #5 clk = ~clk;
  dlfloat_operand_tx_if bus();
  dlfloat_operand_tx #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus), .fifo_count(fifo_count), .busy(busy));

  function automatic logic [15:0] canon(input logic [15:0] x);
`ifdef DLF_CANON_ZERO_EN
    return x == 16'h8000 ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: observe handshakes before the edge, update the model after it
  task automatic tick();
    logic hs, pu, held, bt;
    logic [15:0] d, a, b;
    hs   = bus.tx_valid & bus.tx_ready;
    pu   = bus.in_valid & bus.in_ready;
    held = bus.tx_valid & !bus.tx_ready;
    d = bus.tx_data; bt = bus.tx_beat; a = bus.in_a; b = bus.in_b;
    @(posedge clk);
    #1;
    if (hs) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("beat", {bt, d}, exp_q.pop_front());
    end
    if (pu) begin
      exp_q.push_back({1'b0, canon(a)});
      exp_q.push_back({1'b1, canon(b)});
    end
    if (held) chk("hold", {bus.tx_valid, bus.tx_beat, bus.tx_data}, {1'b1, bt, d});
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 30 && busy; i++) tick();
    chk("drain_idle", busy, 0);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_beat", bus.tx_beat, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    // basic frame, consecutive beats
    bus.tx_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 16'h3E00; bus.in_b = 16'h4000;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_count", fifo_count, 1);
    chk("t1_not_yet", bus.tx_valid, 0);
    tick();
    chk("t1_a", {bus.tx_valid, bus.tx_beat, bus.tx_data}, {1'b1, 1'b0, 16'h3E00});
    chk("t1_count0", fifo_count, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_b", {bus.tx_valid, bus.tx_beat, bus.tx_data}, {1'b1, 1'b1, 16'h4000});
    tick();
    chk("t1_done", {bus.tx_valid, bus.tx_data}, 0);
    chk("t1_busy0", busy, 0);
    // fill while stalled, then stream back to back
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 16'h1000 + 16'(i); bus.in_b = 16'h2000 + 16'(i);
      tick();
    end
    chk("t2_full_count", fifo_count, 4);
    chk("t2_full_ready", bus.in_ready, 0);
    bus.in_a = 16'hDEAD; bus.in_b = 16'hBEEF;
    tick();
    chk("t2_no_overfill", fifo_count, 4);
    bus.in_valid = 1'b0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t2_no_bubble", bus.tx_valid, 1);
      chk("t2_beat_seq", bus.tx_beat, i % 2);
      tick();
    end
    chk("t2_end", bus.tx_valid, 0);
    // stall during beat B
    bus.in_valid = 1'b1; bus.in_a = 16'h3E00; bus.in_b = 16'h4000;
    bus.tx_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_b", {bus.tx_valid, bus.tx_beat, bus.tx_data}, {1'b1, 1'b1, 16'h4000});
    end
    bus.tx_ready = 1'b1;
    tick();
    chk("t3_release", bus.tx_valid, 0);
    // full FIFO, pop does not raise in_ready; push+pop keeps count
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 16'h5000 + 16'(i); bus.in_b = 16'h6000 + 16'(i);
      tick();
    end
    bus.in_a = 16'h7777; bus.in_b = 16'h8888;
    bus.tx_ready = 1'b1;
    tick();
    chk("t4_count_sendb", fifo_count, 4);
    chk("t4_ready_pop", bus.in_ready, 0);
    tick();
    chk("t4_after_pop", fifo_count, 3);
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1; bus.in_a = 16'hAAAA; bus.in_b = 16'hBBBB;
    tick();
    chk("t4_push_pop", fifo_count, 3);
    drain();
    // reset mid-frame
    bus.tx_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 16'h1111; bus.in_b = 16'h2222;
    tick();
    bus.in_a = 16'h3333; bus.in_b = 16'h4444;
    tick();
    bus.in_valid = 1'b0;
    bus.tx_ready = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", bus.tx_valid, 0);
    chk("t5_rst_data", bus.tx_data, 0);
    chk("t5_rst_count", fifo_count, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.tx_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 16'h1234; bus.in_b = 16'h5678;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t5_new_a", {bus.tx_valid, bus.tx_beat, bus.tx_data}, {1'b1, 1'b0, 16'h1234});
    drain();
    // negative zero
    bus.tx_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 16'h8000; bus.in_b = 16'h3E00;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t6_neg_zero", bus.tx_data, canon(16'h8000));
    drain();
    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom);
      bus.in_a = ($urandom % 4 == 0) ? 16'h8000 : 16'($urandom);
      bus.in_b = ($urandom % 4 == 0) ? 16'h8000 : 16'($urandom);
      bus.tx_ready = ($urandom % 3) != 0;
      tick();
      chk("rnd_busy", busy, 32'((fifo_count != 0) | bus.tx_valid));
      chk("rnd_in_ready", bus.in_ready, 32'(fifo_count != 4));
    end
    drain();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
